// File: rtl/multicycle_control.sv
// +----------------------------------------------------------------------------+
// | multicycle_control: main control FSM for the multi-cycle MIPS datapath.    |
// | Optional feature macro: MCTRL_JUMP_EN (builds the JUMP state).             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] c_op_r    = 6'b000000;
  localparam logic [5:0] c_op_lw   = 6'b100011;
  localparam logic [5:0] c_op_sw   = 6'b101011;
  localparam logic [5:0] c_op_beq  = 6'b000100;
  localparam logic [5:0] c_op_andi = 6'b001100;
`ifdef MCTRL_JUMP_EN
  localparam logic [5:0] c_op_j    = 6'b000010;
`endif

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_ANDI_EX = 4'd9,
`ifdef MCTRL_JUMP_EN
    S_ANDI_WB = 4'd10,
    S_JUMP    = 4'd11
`else
    S_ANDI_WB = 4'd10
`endif
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  assign state = r_state;

  always_comb begin
    w_next        = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal_op    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // Strobes masked by rst_n so nothing commits while reset is held.
        pc_write  = mem_ready & rst_n;
        ir_write  = mem_ready & rst_n;
        w_next    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          c_op_lw, c_op_sw: w_next = S_MEMADR;
          c_op_r:           w_next = S_EXEC;
          c_op_beq:         w_next = S_BRANCH;
          c_op_andi:        w_next = S_ANDI_EX;
`ifdef MCTRL_JUMP_EN
          c_op_j:           w_next = S_JUMP;
`endif
          default: begin
            illegal_op = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == c_op_sw) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        w_next   = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        w_next    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_RWB;
      end
      S_RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_ANDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        w_next    = S_ANDI_WB;
      end
      S_ANDI_WB: begin
        reg_write = 1'b1;
      end
`ifdef MCTRL_JUMP_EN
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// +----------------------------------------------------------------------------+
// | tb_multicycle_control: table, random and corner-case bench for the FSM.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MCTRL_JUMP_EN
  localparam bit JUMP_ON = 1'b1;
  localparam int J_CYC   = 3;
`else
  localparam bit JUMP_ON = 1'b0;
  localparam int J_CYC   = 2;
`endif

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] outs_now();
    return {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
            ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
            alu_op, illegal_op};
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_ANDI) || (JUMP_ON && op == OP_J);
  endfunction

  // Expected output word for a state, transcribed from the state table.
  function automatic logic [16:0] exp_out(input int st, input logic [5:0] op, input logic rdy);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill;
    logic [1:0] ps, asb, aop;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
    ps = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      0:  begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
      1:  begin asb = 2'b11; ill = !legal(op); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      9:  begin asa = 1; asb = 2'b10; aop = 2'b11; end
      10: begin rw = 1; end
      11: begin pw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, ps, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ill};
  endfunction

  // Ordered list of states an instruction visits, ignoring wait cycles.
  function automatic void build_path(input logic [5:0] op, ref int path[$]);
    path = {0, 1};
    case (op)
      OP_LW:   path = {0, 1, 2, 3, 4};
      OP_SW:   path = {0, 1, 2, 5};
      OP_R:    path = {0, 1, 6, 7};
      OP_BEQ:  path = {0, 1, 8};
      OP_ANDI: path = {0, 1, 9, 10};
      OP_J:    if (JUMP_ON) path = {0, 1, 11};
      default: ;
    endcase
  endfunction

  // Runs one instruction from FETCH; fw/mw are not-ready cycles in fetch/data access.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           output int cyc, output int nrw, output int nmw, output int npwc);
    int path[$];
    int idx, fcnt, mcnt, st, guard;
    bit is_mem, rdy;
    build_path(op, path);
    idx = 0; fcnt = 0; mcnt = 0; cyc = 0; nrw = 0; nmw = 0; npwc = 0; guard = 0;
    opcode = op;
    while (idx < path.size()) begin
      st = path[idx];
      is_mem = (st == 0) || (st == 3) || (st == 5);
      if (st == 0)       begin rdy = (fcnt >= fw); fcnt++; end
      else if (is_mem)   begin rdy = (mcnt >= mw); mcnt++; end
      else               rdy = $urandom_range(0, 1);
      mem_ready = rdy;
      #2;
      check($sformatf("state op=%b", op), {28'd0, state}, st);
      check($sformatf("outs op=%b st=%0d", op, st), {15'd0, outs_now()}, {15'd0, exp_out(st, op, rdy)});
      nrw  += reg_write;
      nmw  += mem_write;
      npwc += pc_write_cond;
      tick();
      cyc++;
      if (!is_mem || rdy) idx++;
      guard++;
      if (guard > 100) begin
        check("cycle budget", guard, 0);
        break;
      end
    end
  endtask

  typedef struct {
    logic [5:0] op;
    int fw, mw, cyc, rw, memw, pwc;
  } vec_t;

  initial begin
    vec_t tbl[10];
    logic [5:0] ops[7];
    int cyc, nrw, nmw, npwc, fw, mw, path[$];
    logic [5:0] op;

    tbl[0] = '{OP_LW,     0, 0, 5, 1, 0, 0};
    tbl[1] = '{OP_LW,     1, 2, 8, 1, 0, 0};
    tbl[2] = '{OP_SW,     0, 0, 4, 0, 1, 0};
    tbl[3] = '{OP_SW,     0, 3, 7, 0, 4, 0};
    tbl[4] = '{OP_R,      0, 0, 4, 1, 0, 0};
    tbl[5] = '{OP_ANDI,   0, 0, 4, 1, 0, 0};
    tbl[6] = '{OP_BEQ,    0, 0, 3, 0, 0, 1};
    tbl[7] = '{OP_J,      0, 0, J_CYC, 0, 0, 0};
    tbl[8] = '{6'b111111, 0, 0, 2, 0, 0, 0};
    tbl[9] = '{6'b001000, 2, 0, 4, 0, 0, 0};

    // Reset held across an edge: FETCH values with strobes masked.
    rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_LW;
    #2;
    check("rst state", {28'd0, state}, 0);
    check("rst pc_write", {31'd0, pc_write}, 0);
    check("rst ir_write", {31'd0, ir_write}, 0);
    check("rst mem_read", {31'd0, mem_read}, 1);
    tick();
    check("rst state held", {28'd0, state}, 0);
    check("rst ir_write held", {31'd0, ir_write}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].op, tbl[i].fw, tbl[i].mw, cyc, nrw, nmw, npwc);
      check($sformatf("tbl%0d cycles", i), cyc, tbl[i].cyc);
      check($sformatf("tbl%0d reg_write", i), nrw, tbl[i].rw);
      check($sformatf("tbl%0d mem_write", i), nmw, tbl[i].memw);
      check($sformatf("tbl%0d pc_write_cond", i), npwc, tbl[i].pwc);
    end

    // Reset asserted mid-MEMRD while memory is stalled.
    opcode = OP_LW; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #2;
    check("abort pre state", {28'd0, state}, 3);
    rst_n = 1'b0;
    #1;
    check("abort state", {28'd0, state}, 0);
    check("abort reg_write", {31'd0, reg_write}, 0);
    check("abort i_or_d", {31'd0, i_or_d}, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      check("post abort state", {28'd0, state}, 0);
      check("post abort reg_write", {31'd0, reg_write}, 0);
      tick();
    end

    // Randomized instruction stream vs. per-instruction arithmetic model.
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ANDI, OP_J, 6'b000000};
    for (int n = 0; n < 150; n++) begin
      op = ops[$urandom_range(0, 6)];
      if (n % 7 == 6) op = 6'($urandom);
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      build_path(op, path);
      run_instr(op, fw, mw, cyc, nrw, nmw, npwc);
      check("rnd cycles", cyc, path.size() + fw + ((op == OP_LW || op == OP_SW) ? mw : 0));
      check("rnd reg_write", nrw, (op == OP_R || op == OP_LW || op == OP_ANDI) ? 1 : 0);
      check("rnd mem_write", nmw, (op == OP_SW) ? mw + 1 : 0);
      check("rnd pc_write_cond", npwc, (op == OP_BEQ) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath select and write strobe, plus the 2-bit `alu_op` consumed by the ALU control decoder. It is the producer side of the `alu_op` interface and inserts wait states on a memory ready handshake.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  instruction bits [31:26] from the instruction register
- `mem_ready`  in  1  memory completes the current read/write this cycle
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load if ALU zero
- `pc_source`  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `ir_write`  out  1  instruction register load
- `mem_to_reg`  out  1  writeback data: 0 = ALUOut, 1 = MDR
- `reg_dst`  out  1  destination register: 0 = rt, 1 = rd
- `reg_write`  out  1  register file write
- `alu_src_a`  out  1  0 = PC, 1 = A register
- `alu_src_b`  out  2  00 B register, 01 constant 4, 10 immediate, 11 immediate<<2
- `alu_op`  out  2  00 add (lw/sw/address), 01 subtract (beq), 10 R-type funct, 11 AND (andi)
- `illegal_op`  out  1  decoded opcode is unsupported
- `state`  out  4  current state encoding, for debug

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, andi 001100, j 000010.
- Outputs are combinational from state. `pc_write` and `ir_write` in FETCH are the exception: they are also gated by `mem_ready`.
- Any output not listed for a state is 0.
- States, encoding, asserted outputs and next state:
  - FETCH 0: `mem_read`, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00. On `mem_ready`: `ir_write`=1, `pc_write`=1, go to DECODE. Otherwise stay.
  - DECODE 1: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. Next state by opcode: lw/sw to MEMADR, R to EXEC, beq to BRANCH, andi to ANDI_EX, j to JUMP. Any other opcode: `illegal_op`=1, go to FETCH.
  - MEMADR 2: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD 3: `mem_read`, `i_or_d`=1. Go to MEMWB on `mem_ready`, else stay.
  - MEMWB 4: `reg_dst`=0, `mem_to_reg`=1, `reg_write`. Go to FETCH.
  - MEMWR 5: `mem_write`, `i_or_d`=1. Go to FETCH on `mem_ready`, else stay.
  - EXEC 6: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Go to RWB.
  - RWB 7: `reg_dst`=1, `mem_to_reg`=0, `reg_write`. Go to FETCH.
  - BRANCH 8: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`, `pc_source`=01. Go to FETCH.
  - ANDI_EX 9: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11. Go to ANDI_WB.
  - ANDI_WB 10: `reg_dst`=0, `mem_to_reg`=0, `reg_write`. Go to FETCH.
  - JUMP 11: `pc_write`, `pc_source`=10. Go to FETCH.
- Unused encodings 12–15 decode as all-zero outputs and go to FETCH next cycle.
- `opcode` is sampled only in DECODE and MEMADR. The IR holds it stable from FETCH until the next FETCH.

## Timing
- Reset: on `rst_n` low, `state` becomes FETCH (0) immediately, without waiting for a clock edge.
  - While reset is held, outputs show FETCH values, except `pc_write`=0 and `ir_write`=0 (both masked by `rst_n`).
  - Reset in the middle of an instruction aborts it. No strobe from the aborted state appears after `rst_n` falls.
- Cycles per instruction with `mem_ready` held at 1: lw 5, sw 4, R-type 4, andi 4, beq 3, j 3, illegal 2.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- During a wait, the request (`mem_read` or `mem_write`) and `i_or_d` stay asserted and stable.
- `mem_ready` is ignored in every state other than FETCH, MEMRD and MEMWR.
- `mem_ready` may be 1 in the first cycle of a request; that access then completes in one cycle.
- `reg_write`, `mem_write` and `pc_write_cond` are each high for exactly one cycle per instruction (`mem_write` once `mem_ready` is seen).

## Configuration
- `MCTRL_JUMP_EN` defined: opcode 000010 goes to JUMP.
- `MCTRL_JUMP_EN` not defined:
  - The JUMP state is not built.
  - Opcode 000010 is illegal: `illegal_op`=1 in DECODE, then FETCH.
  - `pc_source` never takes the value 10.

## Test plan
- Reset: hold `rst_n`=0 across a clock edge, then release → `state`=0, `pc_write`=`ir_write`=0 during reset, `mem_read`=1.
- lw (100011) with `mem_ready`=1 → state sequence 0,1,2,3,4,0. `alu_op` 00 in state 2. One `reg_write` pulse with `mem_to_reg`=1.
- sw with `mem_ready` low for 3 cycles in MEMWR → 7 total cycles. `mem_write` high for 4 cycles. No `reg_write`.
- R-type then andi then beq → `alu_op` 10 in EXEC, 11 in ANDI_EX, 01 in BRANCH. `reg_dst` 1 for R-type, 0 for andi. `pc_write_cond`=1 in BRANCH only.
- Opcode 111111 → `illegal_op`=1 in DECODE, back in FETCH next cycle. Opcode 000010 behaves per `MCTRL_JUMP_EN`: reaches state 11 with `pc_source`=10 when defined, raises `illegal_op` when not.
- `rst_n` pulsed low in MEMRD while `mem_ready`=0 → immediate return to FETCH. No `reg_write` follows.
